// File: rtl/phy_rx_s2p.sv
// phy_rx_s2p: USB 1.1 receive serial-to-parallel converter.
//
// Takes decoded, unstuffed bits from the NRZI decoder on one-cycle strobes.
// It finds SYNC, builds bytes LSB first and detects SE0 end-of-packet.
// Completed bytes go to the link layer with start/end-of-packet markers.
//
// Ports
//   clk           48 MHz clock
//   rst_n         asynchronous active-low reset
//   rx_dat        decoded bit, qualified by rx_dat_en
//   rx_dat_en     one-cycle bit strobe (at most one per 4 clocks)
//   rx_bit_skip   current bit is a stuffed bit, discard it
//   rx_se0        line was SE0 for this bit time
//   rx_stuff_err  seven consecutive ones were decoded
//   rx_data       received byte, held between rx_valid pulses
//   rx_valid      one-cycle pulse: rx_data/rx_sop/rx_eop are valid
//   rx_sop        first byte of packet (only with rx_valid)
//   rx_eop        last byte of packet (only with rx_valid)
//   rx_err        one-cycle pulse: packet aborted
//   rx_active     high from SYNC detection until return to IDLE
//
// Output handshake: rx_valid is a one-cycle pulse with no back-pressure.
// The consumer must take rx_data/rx_sop/rx_eop in the cycle rx_valid is high.
// rx_valid and rx_err are never high together.
module phy_rx_s2p (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_dat,
  input  logic       rx_dat_en,
  input  logic       rx_bit_skip,
  input  logic       rx_se0,
  input  logic       rx_stuff_err,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_sop,
  output logic       rx_eop,
  output logic       rx_err,
  output logic       rx_active
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DATA  = 2'd1;
  localparam logic [1:0] ST_EOP   = 2'd2;
  localparam logic [1:0] ST_ABORT = 2'd3;

  logic [1:0] state_q, state_d;
  logic [2:0] zcnt_q, zcnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_v_q, hold_v_d;
  logic       first_q, first_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_sop_q, rx_sop_d;
  logic       rx_eop_q, rx_eop_d;
  logic       rx_err_q, rx_err_d;
  logic       rx_active_q, rx_active_d;

  // Byte that results if the current strobe is shifted in.
  logic [7:0] new_byte;
  assign new_byte = {rx_dat, shift_q[7:1]};

  always_comb begin
    state_d     = state_q;
    zcnt_d      = zcnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_v_d    = hold_v_q;
    first_d     = first_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_sop_d    = 1'b0;
    rx_eop_d    = 1'b0;
    rx_err_d    = 1'b0;
    rx_active_d = rx_active_q;

    if (rx_dat_en) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_se0 || rx_stuff_err || rx_bit_skip) begin
            zcnt_d = 3'd0;
          end else if (!rx_dat) begin
            if (zcnt_q != 3'd7) zcnt_d = zcnt_q + 3'd1;
          end else if (zcnt_q >= 3'd5) begin
            // The trailing one of SYNC: bytes start with the next bit.
            state_d     = ST_DATA;
            bit_cnt_d   = 3'd0;
            first_d     = 1'b1;
            hold_v_d    = 1'b0;
            zcnt_d      = 3'd0;
            rx_active_d = 1'b1;
          end else begin
            zcnt_d = 3'd0;
          end
        end

        ST_DATA: begin
          if (rx_se0) begin
            // A clean EOP lands exactly on a byte boundary with a byte held.
            if (bit_cnt_q == 3'd0 && hold_v_q) begin
              rx_valid_d = 1'b1;
              rx_data_d  = hold_q;
              rx_sop_d   = first_q;
              rx_eop_d   = 1'b1;
            end else begin
              rx_err_d = 1'b1;
            end
            hold_v_d = 1'b0;
            state_d  = ST_EOP;
          end else if (rx_stuff_err) begin
            rx_err_d = 1'b1;
            hold_v_d = 1'b0;
            state_d  = ST_ABORT;
          end else if (!rx_bit_skip) begin
            shift_d   = new_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              // The previous byte is released only once another byte
              // follows it, so the last byte can still carry rx_eop.
              if (hold_v_q) begin
                rx_valid_d = 1'b1;
                rx_data_d  = hold_q;
                rx_sop_d   = first_q;
                first_d    = 1'b0;
              end
              hold_d   = new_byte;
              hold_v_d = 1'b1;
            end
          end
        end

        ST_ABORT: begin
          if (rx_se0) state_d = ST_EOP;
        end

        ST_EOP: begin
          if (!rx_se0) begin
            state_d     = ST_IDLE;
            hold_v_d    = 1'b0;
            bit_cnt_d   = 3'd0;
            zcnt_d      = 3'd0;
            rx_active_d = 1'b0;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      zcnt_q      <= 3'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      hold_q      <= 8'h00;
      hold_v_q    <= 1'b0;
      first_q     <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_sop_q    <= 1'b0;
      rx_eop_q    <= 1'b0;
      rx_err_q    <= 1'b0;
      rx_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      zcnt_q      <= zcnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_v_q    <= hold_v_d;
      first_q     <= first_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_sop_q    <= rx_sop_d;
      rx_eop_q    <= rx_eop_d;
      rx_err_q    <= rx_err_d;
      rx_active_q <= rx_active_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_sop    = rx_sop_q;
  assign rx_eop    = rx_eop_q;
  assign rx_err    = rx_err_q;
  assign rx_active = rx_active_q;

endmodule

// File: tb/tb_phy_rx_s2p.sv
// Bench for phy_rx_s2p: directed packets from the test plan plus randomized
// packets. A packet-level model predicts the delivered bytes and error pulses.
module tb_phy_rx_s2p;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_dat = 1'b0;
  logic       rx_dat_en = 1'b0;
  logic       rx_bit_skip = 1'b0;
  logic       rx_se0 = 1'b0;
  logic       rx_stuff_err = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_sop, rx_eop, rx_err, rx_active;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [9:0] exp_q[$];      // {sop, eop, data}
  logic [9:0] cap_q[$];
  int         cap_cyc_q[$];
  logic [7:0] pkt_q[$];
  int exp_err = 0, err_cnt = 0, bad_cnt = 0;
  int rise_cnt = 0, rise_cyc = 0, fall_cyc = 0;
  int last_strobe_cyc = 0, se0_cyc = 0, byte_end_cyc = 0;
  logic       prev_active = 1'b0;
  logic [7:0] prev_data = 8'h00;

  phy_rx_s2p dut (
    .clk(clk), .rst_n(rst_n), .rx_dat(rx_dat), .rx_dat_en(rx_dat_en),
    .rx_bit_skip(rx_bit_skip), .rx_se0(rx_se0), .rx_stuff_err(rx_stuff_err),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eop(rx_eop),
    .rx_err(rx_err), .rx_active(rx_active)
  );

  // ---------------- clock / cycle counter ----------------
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- output monitor (samples on falling edge) ----------------
  always @(negedge clk) begin
    if (rx_valid) begin
      cap_q.push_back({rx_sop, rx_eop, rx_data});
      cap_cyc_q.push_back(cyc);
      if (rx_err) bad_cnt++;
    end
    if (rx_err) err_cnt++;
    if (!rx_valid && (rx_sop || rx_eop)) bad_cnt++;
    if (rst_n && !rx_valid && (rx_data !== prev_data)) bad_cnt++;
    if (rx_active && !prev_active) begin rise_cnt++; rise_cyc = cyc; end
    if (!rx_active && prev_active) fall_cyc = cyc;
    prev_active = rx_active;
    prev_data   = rx_data;
  end

  // ---------------- driver tasks ----------------
  task automatic strobe(input logic d, input logic se0, input logic skip, input logic serr);
    @(negedge clk);
    rx_dat = d; rx_se0 = se0; rx_bit_skip = skip; rx_stuff_err = serr; rx_dat_en = 1'b1;
    last_strobe_cyc = cyc;
    @(negedge clk);
    rx_dat = 1'b0; rx_se0 = 1'b0; rx_bit_skip = 1'b0; rx_stuff_err = 1'b0; rx_dat_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) strobe(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_sync();
    for (int i = 0; i < 7; i++) strobe(1'b0, 1'b0, 1'b0, 1'b0);
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // skip_at: bit index after which a stuffed-bit strobe is inserted (>7: none)
  task automatic send_byte(input logic [7:0] v, input int skip_at);
    for (int i = 0; i < 8; i++) begin
      strobe(v[i], 1'b0, 1'b0, 1'b0);
      if (i == 7) byte_end_cyc = last_strobe_cyc;
      if (i == skip_at) strobe(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic send_eop();
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    se0_cyc = last_strobe_cyc;
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_capture();
    exp_q.delete(); cap_q.delete(); cap_cyc_q.delete();
    exp_err = 0; err_cnt = 0; rise_cnt = 0;
  endtask

  // ---------------- reference model ----------------
  // kind 0: packet ends cleanly after all bytes in pkt_q -> every byte,
  //         sop on first, eop on last.
  // kind 1: packet aborted after the bytes in pkt_q -> all but the last
  //         completed byte are delivered, no eop, one error pulse.
  task automatic model_packet(input int kind);
    int n = pkt_q.size();
    for (int i = 0; i < n; i++) begin
      if (kind == 0) exp_q.push_back({(i == 0), (i == n - 1), pkt_q[i]});
      else if (i < n - 1) exp_q.push_back({(i == 0), 1'b0, pkt_q[i]});
    end
    if (kind != 0) exp_err++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_data, rx_valid, rx_sop, rx_eop, rx_err, rx_active} !== 13'h0) begin
      failures++;
      $display("FAIL reset_state got=%04h exp=0000",
               {rx_data, rx_valid, rx_sop, rx_eop, rx_err, rx_active});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_valid, rx_err, rx_active} !== 3'b000) begin
      failures++;
      $display("FAIL reset_release got=%03b exp=000", {rx_valid, rx_err, rx_active});
    end
  endtask

  task automatic test_two_byte();
    int sync_cyc;
    clear_capture();
    pkt_q = '{8'hA5, 8'h3C};
    model_packet(0);
    send_idle(4);
    send_sync();
    sync_cyc = last_strobe_cyc;
    send_byte(8'hA5, 99);
    send_byte(8'h3C, 99);
    send_eop();
    repeat (2) @(negedge clk);
    checks++;
    if (cap_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL two_byte_count got=%0d exp=%0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL two_byte_byte%0d got={sop,eop,data}=%03h exp=%03h", i, cap_q[i], exp_q[i]);
      end
    end
    checks++;
    if (err_cnt !== exp_err) begin
      failures++;
      $display("FAIL two_byte_err got=%0d exp=%0d", err_cnt, exp_err);
    end
    checks++;
    if (cap_cyc_q.size() < 2 || cap_cyc_q[0] !== byte_end_cyc + 1 || cap_cyc_q[1] !== se0_cyc + 1) begin
      failures++;
      $display("FAIL two_byte_timing got_n=%0d exp_cycles=%0d,%0d", cap_cyc_q.size(),
               byte_end_cyc + 1, se0_cyc + 1);
    end
    checks++;
    if (rise_cyc !== sync_cyc + 1) begin
      failures++;
      $display("FAIL active_rise got=%0d exp=%0d", rise_cyc, sync_cyc + 1);
    end
    checks++;
    if (fall_cyc !== last_strobe_cyc + 1) begin
      failures++;
      $display("FAIL active_fall got=%0d exp=%0d", fall_cyc, last_strobe_cyc + 1);
    end
  endtask

  task automatic test_one_byte();
    clear_capture();
    pkt_q = '{8'hD2};
    model_packet(0);
    send_idle(3);
    send_sync();
    send_byte(8'hD2, 99);
    send_eop();
    checks++;
    if (cap_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL one_byte_count got=%0d exp=%0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL one_byte_byte%0d got={sop,eop,data}=%03h exp=%03h", i, cap_q[i], exp_q[i]);
      end
    end
    checks++;
    if (err_cnt !== exp_err) begin
      failures++;
      $display("FAIL one_byte_err got=%0d exp=%0d", err_cnt, exp_err);
    end
  endtask

  task automatic test_bit_skip();
    clear_capture();
    pkt_q = '{8'hFF};
    model_packet(0);
    send_idle(2);
    send_sync();
    send_byte(8'hFF, 5);
    send_eop();
    checks++;
    if (cap_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL bit_skip_count got=%0d exp=%0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL bit_skip_byte%0d got={sop,eop,data}=%03h exp=%03h", i, cap_q[i], exp_q[i]);
      end
    end
    checks++;
    if (err_cnt !== exp_err) begin
      failures++;
      $display("FAIL bit_skip_err got=%0d exp=%0d", err_cnt, exp_err);
    end
  endtask

  task automatic test_se0_abort();
    clear_capture();
    pkt_q = '{8'h11, 8'h22};
    model_packet(1);
    send_idle(2);
    send_sync();
    send_byte(8'h11, 99);
    send_byte(8'h22, 99);
    for (int i = 0; i < 3; i++) strobe(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    send_eop();
    checks++;
    if (cap_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL se0_abort_count got=%0d exp=%0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL se0_abort_byte%0d got={sop,eop,data}=%03h exp=%03h", i, cap_q[i], exp_q[i]);
      end
    end
    checks++;
    if (err_cnt !== exp_err) begin
      failures++;
      $display("FAIL se0_abort_err got=%0d exp=%0d", err_cnt, exp_err);
    end
  endtask

  task automatic test_bad_sync();
    clear_capture();
    send_idle(3);
    for (int i = 0; i < 4; i++) strobe(1'b0, 1'b0, 1'b0, 1'b0);
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h55, 99);
    send_idle(4);
    checks++;
    if (rise_cnt !== 0 || cap_q.size() !== 0 || err_cnt !== 0) begin
      failures++;
      $display("FAIL bad_sync got rises=%0d bytes=%0d errs=%0d exp=0,0,0", rise_cnt, cap_q.size(), err_cnt);
    end
    pkt_q = '{8'h55};
    model_packet(0);
    send_sync();
    send_byte(8'h55, 99);
    send_eop();
    checks++;
    if (cap_q.size() !== exp_q.size() || (cap_q.size() > 0 && cap_q[0] !== exp_q[0])) begin
      failures++;
      $display("FAIL good_sync_after_bad got_n=%0d exp_n=%0d", cap_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid_packet();
    clear_capture();
    send_idle(3);
    send_sync();
    send_byte(8'h11, 99);
    for (int i = 0; i < 3; i++) strobe(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rx_data, rx_valid, rx_sop, rx_eop, rx_err, rx_active} !== 13'h0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%04h exp=0000",
               {rx_data, rx_valid, rx_sop, rx_eop, rx_err, rx_active});
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (cap_q.size() !== 0 || err_cnt !== 0) begin
      failures++;
      $display("FAIL reset_mid_pulses got bytes=%0d errs=%0d exp=0,0", cap_q.size(), err_cnt);
    end
    clear_capture();
    pkt_q = '{8'h5A, 8'hC3};
    model_packet(0);
    send_idle(3);
    send_sync();
    send_byte(8'h5A, 99);
    send_byte(8'hC3, 99);
    send_eop();
    checks++;
    if (cap_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL reset_next_count got=%0d exp=%0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL reset_next_byte%0d got={sop,eop,data}=%03h exp=%03h", i, cap_q[i], exp_q[i]);
      end
    end
  endtask

  // kind 0: clean packet, kind 1: SE0 mid-byte, kind 2: stuff error then junk
  task automatic test_random();
    for (int p = 0; p < 12; p++) begin
      int kind = p % 3;
      int n = $urandom_range(1, 4);
      clear_capture();
      pkt_q.delete();
      for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
      model_packet(kind == 0 ? 0 : 1);
      send_idle($urandom_range(1, 5));
      send_sync();
      for (int i = 0; i < n; i++) send_byte(pkt_q[i], $urandom_range(0, 15));
      if (kind == 1) begin
        for (int i = 0; i < $urandom_range(1, 7); i++) strobe(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      end else if (kind == 2) begin
        for (int i = 0; i < $urandom_range(0, 7); i++) strobe(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        strobe(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < $urandom_range(0, 3); i++) strobe(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      end
      send_eop();
      checks++;
      if (cap_q.size() !== exp_q.size()) begin
        failures++;
        $display("FAIL random%0d_count kind=%0d got=%0d exp=%0d", p, kind, cap_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
        checks++;
        if (cap_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL random%0d_byte%0d got={sop,eop,data}=%03h exp=%03h", p, i, cap_q[i], exp_q[i]);
        end
      end
      checks++;
      if (err_cnt !== exp_err) begin
        failures++;
        $display("FAIL random%0d_err kind=%0d got=%0d exp=%0d", p, kind, err_cnt, exp_err);
      end
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (bad_cnt !== 0) begin
      failures++;
      $display("FAIL output_invariants got=%0d violations exp=0", bad_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_two_byte();
    test_one_byte();
    test_bit_skip();
    test_se0_abort();
    test_bad_sync();
    test_reset_mid_packet();
    test_random();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
